// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file write-back path.
// REG_ADDR_W/NUM_REGS describe the 3-to-8 write-enable decoder that the
// write queue feeds; wq_entry_t is one queued write at the default width.
package regfile_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wq_entry_t;

  // Width of an occupancy counter that must hold the value 'depth' itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/regfile_wr_queue_if.sv
// regfile_wr_queue_if: request, drain and bypass-lookup signals of the
// register-file write queue. The master side is the producer / register
// file, the slave side is the queue itself.
interface regfile_wr_queue_if #(
  parameter int DATA_W = 32
);
  import regfile_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [REG_ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]     req_data;
  logic                  stall;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  byp_hit;
  logic [DATA_W-1:0]     byp_data;

  modport master (
    output req_valid, req_addr, req_data, stall, rd_addr,
    input  req_ready, wr_en, wr_addr, wr_data, byp_hit, byp_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, stall, rd_addr,
    output req_ready, wr_en, wr_addr, wr_data, byp_hit, byp_data
  );

endinterface

// File: rtl/regfile_wq_match.sv
// regfile_wq_match: youngest-first lookup of a register index over the
// valid entries of the write queue. Entries are scanned oldest to youngest
// starting at the head, so the last match found is the youngest one.
// Only instantiated when REGFILE_WQ_BYPASS_EN is defined.
module regfile_wq_match #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic [regfile_pkg::REG_ADDR_W-1:0] rd_addr_i,
  input  logic [$clog2(DEPTH)-1:0]           head_i,
  input  logic [$clog2(DEPTH):0]             count_i,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] ent_addr_i [DEPTH],
  input  logic [DATA_W-1:0]                  ent_data_i [DEPTH],
  output logic                               hit_o,
  output logic [DATA_W-1:0]                  data_o
);
  import regfile_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Scan valid entries in age order; a later (younger) match overrides.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if ((CNT_W'(i) < count_i) && (ent_addr_i[idx] == rd_addr_i)) begin
        hit_o  = 1'b1;
        data_o = ent_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_wr_queue.sv
// regfile_wr_queue: write-back FIFO in front of the register file's
// 3-to-8 write-enable decoder. Drains at most one entry per cycle as
// wr_en/wr_addr/wr_data; never falls through in the cycle of the push.
// Optional macro REGFILE_WQ_BYPASS_EN adds the combinational lookup of
// queued data by rd_addr; without it byp_hit/byp_data are tied to 0.
module regfile_wr_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_wr_queue_if.slave       q_if,
  output logic [$clog2(DEPTH):0]  count
);
  import regfile_pkg::*;

  localparam int               PTR_W = $clog2(DEPTH);
  localparam int               CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic [REG_ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [DATA_W-1:0]     ent_data_q [DEPTH];

  logic not_empty;
  logic push;
  logic pop;

  assign not_empty = (count_q != '0);

  // Full blocks pushes even when a pop happens in the same cycle.
  assign q_if.req_ready = !rst && (count_q != FULL);
  assign push           = q_if.req_valid && q_if.req_ready;

  assign q_if.wr_en   = not_empty && !q_if.stall && !rst;
  assign pop          = q_if.wr_en;
  assign q_if.wr_addr = not_empty ? ent_addr_q[rd_ptr_q] : '0;
  assign q_if.wr_data = not_empty ? ent_data_q[rd_ptr_q] : '0;

  assign count = count_q;

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; left unreset because every reader is masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[wr_ptr_q] <= q_if.req_addr;
      ent_data_q[wr_ptr_q] <= q_if.req_data;
    end
  end

`ifdef REGFILE_WQ_BYPASS_EN
  regfile_wq_match #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_match (
    .rd_addr_i  (q_if.rd_addr),
    .head_i     (rd_ptr_q),
    .count_i    (count_q),
    .ent_addr_i (ent_addr_q),
    .ent_data_i (ent_data_q),
    .hit_o      (q_if.byp_hit),
    .data_o     (q_if.byp_data)
  );
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^q_if.rd_addr;
  assign q_if.byp_hit   = 1'b0;
  assign q_if.byp_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_queue.sv
// tb_regfile_wr_queue: directed vectors for regfile_wr_queue, then a
// streaming wrap-around sequence checked against a queue model.
module tb_regfile_wr_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;
`ifdef REGFILE_WQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] count;
  int         n_tests = 0;
  int         n_fail  = 0;

  regfile_wr_queue_if #(.DATA_W(32)) q_if ();

  regfile_wr_queue #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .q_if  (q_if.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic [2:0]  rd;
    logic        e_ready;
    logic        e_wr_en;
    logic [2:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_hit;
    logic [31:0] e_bdata;
    logic [2:0]  e_count;
    logic        care;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic v, input logic [2:0] a,
                              input logic [31:0] d, input logic s, input logic [2:0] rd,
                              input logic er, input logic ew, input logic [2:0] ea,
                              input logic [31:0] ed, input logic eh, input logic [31:0] eb,
                              input logic [2:0] ec, input logic care);
    vec_t x;
    x.rst = r; x.valid = v; x.addr = a; x.data = d; x.stall = s; x.rd = rd;
    x.e_ready = er; x.e_wr_en = ew; x.e_waddr = ea; x.e_wdata = ed;
    x.e_hit = eh; x.e_bdata = eb; x.e_count = ec; x.care = care;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [2:0]  qa [$];
  logic [31:0] qd [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e_ready, e_wr_en, e_hit, valid, stall;
    logic [2:0]  e_waddr;
    logic [31:0] e_wdata, e_bdata;
    int          n_push;

    //            rst v addr data     st rd | rdy wen wa wdata    hit bdata    cnt care
    vecs[0]  = mk(1, 0, 0, 32'h0,     0, 0,   0,  0,  0, 32'h0,   0, 32'h0,   0, 1);
    vecs[1]  = mk(0, 1, 3, 32'hA5,    0, 3,   1,  0,  0, 32'h0,   0, 32'h0,   0, 1);
    vecs[2]  = mk(0, 0, 0, 32'h0,     0, 3,   1,  1,  3, 32'hA5,  1, 32'hA5,  1, 1);
    vecs[3]  = mk(0, 0, 0, 32'h0,     0, 3,   1,  0,  0, 32'h0,   0, 32'h0,   0, 1);
    vecs[4]  = mk(0, 1, 0, 32'h10,    1, 7,   1,  0,  0, 32'h0,   0, 32'h0,   0, 1);
    vecs[5]  = mk(0, 1, 1, 32'h11,    1, 7,   1,  0,  0, 32'h10,  0, 32'h0,   1, 1);
    vecs[6]  = mk(0, 1, 2, 32'h12,    1, 7,   1,  0,  0, 32'h10,  0, 32'h0,   2, 1);
    vecs[7]  = mk(0, 1, 3, 32'h13,    1, 7,   1,  0,  0, 32'h10,  0, 32'h0,   3, 1);
    vecs[8]  = mk(0, 1, 4, 32'h14,    1, 2,   0,  0,  0, 32'h10,  1, 32'h12,  4, 1);
    vecs[9]  = mk(0, 1, 4, 32'h14,    0, 2,   0,  1,  0, 32'h10,  1, 32'h12,  4, 1);
    vecs[10] = mk(0, 1, 4, 32'h14,    0, 0,   1,  1,  1, 32'h11,  0, 32'h0,   3, 1);
    vecs[11] = mk(0, 0, 0, 32'h0,     0, 4,   1,  1,  2, 32'h12,  1, 32'h14,  3, 1);
    vecs[12] = mk(0, 0, 0, 32'h0,     0, 2,   1,  1,  3, 32'h13,  0, 32'h0,   2, 1);
    vecs[13] = mk(0, 0, 0, 32'h0,     0, 4,   1,  1,  4, 32'h14,  1, 32'h14,  1, 1);
    vecs[14] = mk(0, 0, 0, 32'h0,     0, 4,   1,  0,  0, 32'h0,   0, 32'h0,   0, 1);
    vecs[15] = mk(0, 1, 5, 32'h11,    1, 5,   1,  0,  0, 32'h0,   0, 32'h0,   0, 1);
    vecs[16] = mk(0, 1, 5, 32'h22,    1, 5,   1,  0,  5, 32'h11,  1, 32'h11,  1, 1);
    vecs[17] = mk(0, 0, 0, 32'h0,     1, 5,   1,  0,  5, 32'h11,  1, 32'h22,  2, 1);
    vecs[18] = mk(0, 0, 0, 32'h0,     1, 6,   1,  0,  5, 32'h11,  0, 32'h0,   2, 1);
    vecs[19] = mk(0, 1, 1, 32'h33,    1, 5,   1,  0,  5, 32'h11,  1, 32'h22,  2, 1);
    vecs[20] = mk(1, 1, 2, 32'h44,    0, 5,   0,  0,  0, 32'h0,   0, 32'h0,   3, 0);
    vecs[21] = mk(0, 0, 0, 32'h0,     0, 5,   1,  0,  0, 32'h0,   0, 32'h0,   0, 1);
    vecs[22] = mk(0, 0, 0, 32'h0,     0, 5,   1,  0,  0, 32'h0,   0, 32'h0,   0, 1);

    rst = 1'b1;
    q_if.req_valid = 1'b0;
    q_if.req_addr  = '0;
    q_if.req_data  = '0;
    q_if.stall     = 1'b0;
    q_if.rd_addr   = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      q_if.req_valid = vecs[i].valid;
      q_if.req_addr  = vecs[i].addr;
      q_if.req_data  = vecs[i].data;
      q_if.stall     = vecs[i].stall;
      q_if.rd_addr   = vecs[i].rd;
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(q_if.req_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d wr_en", i),     32'(q_if.wr_en),     32'(vecs[i].e_wr_en));
      chk($sformatf("v%0d count", i),     32'(count),          32'(vecs[i].e_count));
      if (vecs[i].care) begin
        chk($sformatf("v%0d wr_addr", i),  32'(q_if.wr_addr), 32'(vecs[i].e_waddr));
        chk($sformatf("v%0d wr_data", i),  q_if.wr_data,      vecs[i].e_wdata);
        chk($sformatf("v%0d byp_hit", i),  32'(q_if.byp_hit), BYP ? 32'(vecs[i].e_hit) : 32'h0);
        chk($sformatf("v%0d byp_data", i), q_if.byp_data,     BYP ? vecs[i].e_bdata : 32'h0);
      end
    end

    // Streaming sequence with stalls and a full burst; 16 pushes wrap the
    // four-entry ring several times.
    n_push = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      valid = (n_push < 16) && (c % 3 != 2);
      stall = (c % 5 == 4) || (c >= 20 && c < 26);
      q_if.req_valid = valid;
      q_if.req_addr  = 3'(n_push % 8);
      q_if.req_data  = 32'hC000_0000 + 32'(n_push);
      q_if.stall     = stall;
      q_if.rd_addr   = 3'(c % 8);
      #1;
      e_ready = (qa.size() != DEPTH);
      e_wr_en = (qa.size() != 0) && !stall;
      e_waddr = (qa.size() != 0) ? qa[0] : 3'h0;
      e_wdata = (qa.size() != 0) ? qd[0] : 32'h0;
      e_hit   = 1'b0;
      e_bdata = 32'h0;
      for (int k = 0; k < qa.size(); k++) begin
        if (qa[k] == 3'(c % 8)) begin
          e_hit   = 1'b1;
          e_bdata = qd[k];
        end
      end
      if (!BYP) begin
        e_hit   = 1'b0;
        e_bdata = 32'h0;
      end
      chk($sformatf("wrap c%0d count", c),     32'(count),          32'(qa.size()));
      chk($sformatf("wrap c%0d req_ready", c), 32'(q_if.req_ready), 32'(e_ready));
      chk($sformatf("wrap c%0d wr_en", c),     32'(q_if.wr_en),     32'(e_wr_en));
      chk($sformatf("wrap c%0d wr_addr", c),   32'(q_if.wr_addr),   32'(e_waddr));
      chk($sformatf("wrap c%0d wr_data", c),   q_if.wr_data,        e_wdata);
      chk($sformatf("wrap c%0d byp_hit", c),   32'(q_if.byp_hit),   32'(e_hit));
      chk($sformatf("wrap c%0d byp_data", c),  q_if.byp_data,       e_bdata);
      if (e_wr_en) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (valid && e_ready) begin
        qa.push_back(3'(n_push % 8));
        qd.push_back(32'hC000_0000 + 32'(n_push));
        n_push++;
      end
    end

    // Drain whatever remains, then confirm the queue reads back empty.
    for (int k = 0; k < 2 * DEPTH && qa.size() != 0; k++) begin
      @(negedge clk);
      q_if.req_valid = 1'b0;
      q_if.stall     = 1'b0;
      #1;
      chk($sformatf("drain k%0d wr_en", k),   32'(q_if.wr_en),   32'h1);
      chk($sformatf("drain k%0d wr_addr", k), 32'(q_if.wr_addr), 32'(qa[0]));
      chk($sformatf("drain k%0d wr_data", k), q_if.wr_data,      qd[0]);
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    @(negedge clk);
    q_if.req_valid = 1'b0;
    q_if.stall     = 1'b0;
    #1;
    chk("final count", 32'(count),        32'h0);
    chk("final wr_en", 32'(q_if.wr_en),   32'h0);
    chk("final pushes", 32'(n_push),      32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
